// File: rtl/adc_gain_offset.sv
// Per-lane offset removal and fixed-point gain for parallel ADC samples, with fenced coefficient
// updates (stall input, drain pipeline, then load) and a saturated-beat counter.
module adc_gain_offset #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 16,
  parameter int SCALE_WIDTH      = 18,
  parameter int SCALE_FRAC_BITS  = 16,
  parameter int SAT_COUNT_WIDTH  = 32
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] data_in_data_i,
  input  logic                                     data_in_valid_i,
  output logic                                     data_in_ready_o,
  output logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] data_out_data_o,
  output logic                                     data_out_valid_o,
  input  logic                                     data_out_ready_i,
  input  logic [SCALE_WIDTH-1:0]                   scale_factor_data_i,
  input  logic                                     scale_factor_valid_i,
  output logic                                     scale_factor_ready_o,
  input  logic [SAMPLE_WIDTH-1:0]                  offset_data_i,
  input  logic                                     offset_valid_i,
  output logic                                     offset_ready_o,
  input  logic                                     sat_count_clear_i,
  output logic [SAT_COUNT_WIDTH-1:0]               sat_count_o
);

  localparam int BW = SAMPLE_WIDTH * PARALLEL_SAMPLES;
  localparam int DW = SAMPLE_WIDTH + 1;
  localparam int PW = DW + SCALE_WIDTH;
  localparam int RW = PW - SCALE_FRAC_BITS;
  localparam logic signed [SCALE_WIDTH-1:0] SCALE_ONE = SCALE_WIDTH'(1) << SCALE_FRAC_BITS;
  localparam logic signed [PW-1:0]          HALF      = PW'(1) << (SCALE_FRAC_BITS - 1);
  localparam logic signed [RW-1:0]          Y_MAX     = RW'((2 ** (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0]          Y_MIN     = RW'(-(2 ** (SAMPLE_WIDTH - 1)));

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;

  state_t                         state_q, state_d;
  logic signed [SCALE_WIDTH-1:0]  scale_q, pend_scale_q;
  logic signed [SAMPLE_WIDTH-1:0] offset_q, pend_offset_q;
  logic                           v1_q, v2_q, v3_q;
  logic signed [DW-1:0]           d1_q [PARALLEL_SAMPLES];
  logic signed [DW-1:0]           d1_d [PARALLEL_SAMPLES];
  logic signed [PW-1:0]           p2_q [PARALLEL_SAMPLES];
  logic signed [PW-1:0]           p2_d [PARALLEL_SAMPLES];
  logic [BW-1:0]                  y3_q, y3_d;
  logic                           sat3_q, sat3_d;
  logic [SAT_COUNT_WIDTH-1:0]     sat_cnt_q, sat_cnt_d;
  logic                           adv, coef_req, in_fire, out_fire;

  assign adv      = !v3_q || data_out_ready_i;
  assign coef_req = scale_factor_valid_i || offset_valid_i;
  assign in_fire  = data_in_valid_i && data_in_ready_o;
  assign out_fire = v3_q && data_out_ready_i;

  always_comb begin
    state_d              = state_q;
    data_in_ready_o      = 1'b0;
    scale_factor_ready_o = 1'b0;
    offset_ready_o       = 1'b0;
    case (state_q)
      ST_RUN: begin
        scale_factor_ready_o = reset_n;
        offset_ready_o       = reset_n;
        data_in_ready_o      = reset_n && adv && !coef_req;
        if (coef_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!v1_q && !v2_q && !v3_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    logic signed [SAMPLE_WIDTH-1:0] xs;
    logic signed [PW-1:0]           sum;
    logic signed [RW-1:0]           r;
    xs     = '0;
    sum    = '0;
    r      = '0;
    y3_d   = '0;
    sat3_d = 1'b0;
    for (int unsigned i = 0; i < PARALLEL_SAMPLES; i++) begin
      xs      = data_in_data_i[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      d1_d[i] = DW'(xs) - DW'(offset_q);
      p2_d[i] = PW'(d1_q[i]) * PW'(scale_q);
      // round half up, then clip to the signed sample range
      sum = p2_q[i] + HALF;
      r   = RW'(sum >>> SCALE_FRAC_BITS);
      if (r > Y_MAX) begin
        y3_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = Y_MAX[SAMPLE_WIDTH-1:0];
        sat3_d = 1'b1;
      end else if (r < Y_MIN) begin
        y3_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = Y_MIN[SAMPLE_WIDTH-1:0];
        sat3_d = 1'b1;
      end else begin
        y3_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r[SAMPLE_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_count_clear_i)                         sat_cnt_d = '0;
    else if (out_fire && sat3_q && !(&sat_cnt_q))  sat_cnt_d = sat_cnt_q + SAT_COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      scale_q       <= SCALE_ONE;
      offset_q      <= '0;
      pend_scale_q  <= '0;
      pend_offset_q <= '0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      v3_q          <= 1'b0;
      d1_q          <= '{default: '0};
      p2_q          <= '{default: '0};
      y3_q          <= '0;
      sat3_q        <= 1'b0;
      sat_cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sat_cnt_q <= sat_cnt_d;
      // an unwritten coefficient keeps its active value across the fence
      if (state_q == ST_RUN && coef_req) begin
        pend_scale_q  <= scale_factor_valid_i ? scale_factor_data_i : scale_q;
        pend_offset_q <= offset_valid_i ? offset_data_i : offset_q;
      end
      if (state_q == ST_LOAD) begin
        scale_q  <= pend_scale_q;
        offset_q <= pend_offset_q;
      end
      if (adv) begin
        v1_q   <= in_fire;
        d1_q   <= d1_d;
        v2_q   <= v1_q;
        p2_q   <= p2_d;
        v3_q   <= v2_q;
        y3_q   <= y3_d;
        sat3_q <= sat3_d;
      end
    end
  end

  assign data_out_data_o  = y3_q;
  assign data_out_valid_o = v3_q;
  assign sat_count_o      = sat_cnt_q;

endmodule

// File: tb/tb_adc_gain_offset.sv
// Directed and scoreboard checks for adc_gain_offset: latency, gain/offset arithmetic,
// saturation counting, fenced coefficient updates, backpressure and mid-stream reset.
module tb_adc_gain_offset;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [255:0] data_in_data_i = '0;
  logic         data_in_valid_i = 1'b0;
  logic         data_in_ready_o;
  logic [255:0] data_out_data_o;
  logic         data_out_valid_o;
  logic         data_out_ready_i = 1'b1;
  logic [17:0]  scale_factor_data_i = '0;
  logic         scale_factor_valid_i = 1'b0;
  logic         scale_factor_ready_o;
  logic [15:0]  offset_data_i = '0;
  logic         offset_valid_i = 1'b0;
  logic         offset_ready_o;
  logic         sat_count_clear_i = 1'b0;
  logic [31:0]  sat_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  adc_gain_offset #(
    .SAMPLE_WIDTH(16), .PARALLEL_SAMPLES(16), .SCALE_WIDTH(18),
    .SCALE_FRAC_BITS(16), .SAT_COUNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .data_in_data_i(data_in_data_i), .data_in_valid_i(data_in_valid_i), .data_in_ready_o(data_in_ready_o),
    .data_out_data_o(data_out_data_o), .data_out_valid_o(data_out_valid_o), .data_out_ready_i(data_out_ready_i),
    .scale_factor_data_i(scale_factor_data_i), .scale_factor_valid_i(scale_factor_valid_i),
    .scale_factor_ready_o(scale_factor_ready_o),
    .offset_data_i(offset_data_i), .offset_valid_i(offset_valid_i), .offset_ready_o(offset_ready_o),
    .sat_count_clear_i(sat_count_clear_i), .sat_count_o(sat_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rep(input logic [15:0] x);
    rep = {16{x}};
  endfunction

  function automatic logic [255:0] rand_beat();
    logic [255:0] b;
    for (int i = 0; i < 16; i++) b[i*16 +: 16] = 16'($urandom());
    return b;
  endfunction

  function automatic logic [15:0] lane_model(input logic [15:0] x, input logic [17:0] sc, input logic [15:0] off);
    longint d, p, r;
    d = longint'($signed(x)) - longint'($signed(off));
    p = d * longint'($signed(sc));
    r = (p + 64'sd32768) >>> 16;
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  function automatic logic [255:0] beat_model(input logic [255:0] x, input logic [17:0] sc, input logic [15:0] off);
    logic [255:0] y;
    for (int i = 0; i < 16; i++) y[i*16 +: 16] = lane_model(x[i*16 +: 16], sc, off);
    return y;
  endfunction

  // scoreboard: expected beats computed at input handshake with the coefficients the bench has written
  logic [255:0] exp_q[$];
  logic [17:0]  m_scale = 18'h10000;
  logic [15:0]  m_off   = '0;
  bit           have_hold = 1'b0;
  logic [255:0] hold_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_scale   = 18'h10000;
      m_off     = '0;
      have_hold = 1'b0;
    end else begin
      if (have_hold) check("valid_held", data_out_valid_o, 1'b1);
      if (data_out_valid_o) begin
        if (have_hold) check("out_stable", data_out_data_o, hold_data);
        if (data_out_ready_i) begin
          check("sb_nonempty", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("sb_data", data_out_data_o, exp_q.pop_front());
          have_hold = 1'b0;
        end else begin
          have_hold = 1'b1;
          hold_data = data_out_data_o;
        end
      end else begin
        have_hold = 1'b0;
      end
      if (data_in_valid_i && data_in_ready_o) exp_q.push_back(beat_model(data_in_data_i, m_scale, m_off));
      if (scale_factor_valid_i && scale_factor_ready_o) m_scale = scale_factor_data_i;
      if (offset_valid_i && offset_ready_o) m_off = offset_data_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [15:0] x);
    data_in_valid_i = 1'b1;
    data_in_data_i  = rep(x);
    check(tag, data_in_ready_o, 1'b1);
    tick();
    data_in_valid_i = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [255:0] exp);
    for (int k = 0; k < 10; k++) begin
      if (data_out_valid_o) break;
      tick();
    end
    check({tag, "_valid"}, data_out_valid_o, 1'b1);
    check(tag, data_out_data_o, exp);
  endtask

  task automatic write_coef(input bit sv, input logic [17:0] s, input bit ov, input logic [15:0] o);
    scale_factor_valid_i = sv;
    scale_factor_data_i  = s;
    offset_valid_i       = ov;
    offset_data_i        = o;
    check("coef_ready", scale_factor_ready_o && offset_ready_o, 1'b1);
    tick();
    scale_factor_valid_i = 1'b0;
    offset_valid_i       = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (data_in_ready_o) break;
      tick();
    end
    check("coef_return", data_in_ready_o, 1'b1);
  endtask

  task automatic drain();
    data_in_valid_i  = 1'b0;
    data_out_ready_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (exp_q.size() == 0 && !data_out_valid_o) break;
    end
    check("drain_q_empty", exp_q.size(), 0);
    check("drain_idle", data_out_valid_o, 1'b0);
  endtask

  task automatic stream(input int n_beats, input int wr_at, input logic [17:0] sc,
                        input int rdy_pct, input int vld_pct);
    int acc, cyc, stall;
    bit meas, meas_done, in_fire, sf_fire;
    acc = 0; cyc = 0; stall = 0; meas = 0; meas_done = 0;
    data_in_data_i  = rand_beat();
    data_in_valid_i = ($urandom_range(99) < vld_pct);
    while (acc < n_beats && cyc < 20000) begin
      if (wr_at >= 0 && cyc >= wr_at - 4 && cyc <= wr_at + 10) data_out_ready_i = 1'b1;
      else data_out_ready_i = ($urandom_range(99) < rdy_pct);
      if (cyc == wr_at) begin
        scale_factor_valid_i = 1'b1;
        scale_factor_data_i  = sc;
      end
      @(negedge clk);
      in_fire = data_in_valid_i && data_in_ready_o;
      sf_fire = scale_factor_valid_i && scale_factor_ready_o;
      if (sf_fire) meas = 1'b1;
      if (meas && !meas_done) begin
        if (!data_in_ready_o) stall++;
        else meas_done = 1'b1;
      end
      tick();
      if (in_fire) begin
        acc++;
        data_in_data_i = rand_beat();
      end
      if (in_fire || !data_in_valid_i) data_in_valid_i = ($urandom_range(99) < vld_pct);
      if (sf_fire) scale_factor_valid_i = 1'b0;
      cyc++;
    end
    check("stream_budget", cyc < 20000, 1'b1);
    if (wr_at >= 0) begin
      check("coef_fenced", meas_done, 1'b1);
      check("coef_stall_ge5", stall >= 5, 1'b1);
    end
    data_in_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset defaults, unity gain, 3-cycle latency
    #1 reset_n = 1'b0;
    data_in_valid_i = 1'b1;
    data_in_data_i  = rep(16'h1234);
    repeat (3) tick();
    check("rst_out_valid", data_out_valid_o, 1'b0);
    check("rst_out_data", data_out_data_o, '0);
    check("rst_sat", sat_count_o, '0);
    check("rst_in_ready", data_in_ready_o, 1'b0);
    check("rst_coef_ready", scale_factor_ready_o || offset_ready_o, 1'b0);
    data_in_valid_i = 1'b0;
    reset_n = 1'b1;
    tick();
    send("t1_in_ready", 16'h1234);
    check("t1_lat1", data_out_valid_o, 1'b0);
    tick();
    check("t1_lat2", data_out_valid_o, 1'b0);
    tick();
    check("t1_lat3_valid", data_out_valid_o, 1'b1);
    check("t1_data", data_out_data_o, rep(16'h1234));
    tick();
    check("t1_sat", sat_count_o, '0);

    // 2: half gain with offset, round half up
    write_coef(1'b1, 18'h08000, 1'b1, 16'h0100);
    send("t2_in_a", 16'h0300);
    expect_out("t2_pos", rep(16'h0100));
    send("t2_in_b", 16'hFFFF);
    expect_out("t2_neg_round", rep(16'hFF80));
    tick();

    // 3: near-2x gain saturates both ways; counter and clear
    write_coef(1'b1, 18'h1FFFF, 1'b1, 16'h0000);
    send("t3_in_a", 16'h7000);
    expect_out("t3_sat_hi", rep(16'h7FFF));
    send("t3_in_b", 16'h9000);
    expect_out("t3_sat_lo", rep(16'h8000));
    tick();
    check("t3_cnt2", sat_count_o, 32'd2);
    send("t3_in_c", 16'h0100);
    expect_out("t3_nonsat", rep(16'h0200));
    tick();
    check("t3_nonsat_cnt", sat_count_o, 32'd2);
    send("t3_in_d", 16'h7000);
    expect_out("t3_sat_again", rep(16'h7FFF));
    sat_count_clear_i = 1'b1;
    tick();
    sat_count_clear_i = 1'b0;
    check("t3_clear_wins", sat_count_o, '0);

    // 4: scale write mid-stream under random backpressure
    stream(200, 60, 18'h0C000, 50, 100);
    drain();

    // 5: long random stream with backpressure
    stream(1000, -1, '0, 50, 80);
    drain();

    // 6a: reset mid-stream
    write_coef(1'b1, 18'h1FFFF, 1'b1, 16'h0000);
    data_in_valid_i = 1'b1;
    data_in_data_i  = rep(16'h7000);
    repeat (5) tick();
    check("t6_pre_sat", sat_count_o != 0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", data_out_valid_o, 1'b0);
    check("t6_rst_sat", sat_count_o, '0);
    tick();
    check("t6_rst_in_ready", data_in_ready_o, 1'b0);
    tick();
    data_in_valid_i = 1'b0;
    reset_n = 1'b1;
    tick();
    send("t6_in_a", 16'h1234);
    expect_out("t6_unity", rep(16'h1234));
    tick();

    // 6b: reset while draining for a pending coefficient
    data_out_ready_i = 1'b0;
    data_in_valid_i  = 1'b1;
    data_in_data_i   = rep(16'h0200);
    repeat (4) tick();
    data_in_valid_i      = 1'b0;
    scale_factor_valid_i = 1'b1;
    scale_factor_data_i  = 18'h08000;
    offset_valid_i       = 1'b1;
    offset_data_i        = 16'h0100;
    tick();
    scale_factor_valid_i = 1'b0;
    offset_valid_i       = 1'b0;
    tick();
    check("t6_drain_stall", data_in_ready_o, 1'b0);
    check("t6_drain_valid", data_out_valid_o, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_drain_rst_valid", data_out_valid_o, 1'b0);
    check("t6_drain_rst_sat", sat_count_o, '0);
    tick();
    reset_n = 1'b1;
    data_out_ready_i = 1'b1;
    tick();
    send("t6_in_b", 16'h0300);
    expect_out("t6_pending_dropped", rep(16'h0300));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
